// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side line port and memory-side burst bus bundles for cacheline_burst_adaptor.
// The adaptor is the slave of the pmem bundle and the master of the mem bundle.
interface cacheline_pmem_if #(
  parameter int s_line = 256
);
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

interface cacheline_mem_if #(
  parameter int s_burst = 64
);
  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [s_burst-1:0] mem_wdata;
  logic [s_burst-1:0] mem_rdata;
  logic               mem_resp;
  logic               mem_error;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, mem_error,
    input  mem_rdata, mem_resp
  );
  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, mem_error,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Line read/writeback to num_beats-beat burst; optional watchdog under CACHELINE_BURST_ADAPTOR_TIMEOUT_EN.
// Latency: burst from cycle 1, pmem_resp at num_beats+1; beats wait on mem_resp, one request in flight.
module cacheline_burst_adaptor #(
  parameter int s_line         = 256,
  parameter int s_burst        = 64,
  parameter int num_beats      = s_line / s_burst,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  cacheline_pmem_if.slave  pmem,
  cacheline_mem_if.master  mem
);

  localparam int cnt_w = $clog2(num_beats);

  if (num_beats < 2 || (num_beats & (num_beats - 1)) != 0 ||
      num_beats * s_burst != s_line || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cacheline_burst_adaptor: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, RBURST, WBURST, DONE} state_t;

  state_t            state, state_d;
  logic [cnt_w-1:0]  beat_cnt;
  logic [31:0]       addr_q;
  logic [s_line-1:0] line_q;
  logic [s_line-1:0] rdata_q;
  logic              in_burst;
  logic              beat_acc;
  logic              last_beat;
  logic              tmo_hit;

  assign in_burst  = (state == RBURST) || (state == WBURST);
  assign beat_acc  = in_burst && mem.mem_resp;
  assign last_beat = beat_acc && (beat_cnt == cnt_w'(num_beats - 1));

`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
  localparam int tmo_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [tmo_w-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive burst cycle without a beat.
  assign tmo_hit = in_burst && !mem.mem_resp && (tmo_cnt == tmo_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!in_burst || mem.mem_resp) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign mem.mem_error = err_q;
`else
  assign tmo_hit       = 1'b0;
  assign mem.mem_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (pmem.pmem_write)     state_d = WBURST;
        else if (pmem.pmem_read) state_d = RBURST;
      end
      RBURST, WBURST: begin
        if (last_beat || tmo_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured only in IDLE, so mid-burst input changes never reach the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && (pmem.pmem_write || pmem.pmem_read))
        addr_q <= pmem.pmem_address & 32'hFFFF_FFE0;
      if (state == IDLE && pmem.pmem_write)
        line_q <= pmem.pmem_wdata;
      if (beat_acc) begin
        if (state == RBURST)
          rdata_q[int'(beat_cnt)*s_burst +: s_burst] <= mem.mem_rdata;
        if (!last_beat)
          beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == DONE)
        beat_cnt <= '0;
    end
  end

  assign mem.mem_address = addr_q;
  assign mem.mem_read    = (state == RBURST);
  assign mem.mem_write   = (state == WBURST);
  assign mem.mem_wdata   = line_q[int'(beat_cnt)*s_burst +: s_burst];

  assign pmem.pmem_rdata = rdata_q;
  assign pmem.pmem_resp  = (state == DONE);

endmodule
